// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - Prescaled LED pattern generator with chase, bounce, blink and fill modes
// All state changes on the rising edge of clk; rst is synchronous and active-high.
module led_sequencer #(
  parameter int N_LEDS = 4,
  parameter int DIV_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [DIV_W-1:0]  period,
  output logic [N_LEDS-1:0] led,
  output logic              step
);

  localparam int PW = $clog2(N_LEDS + 1);

  typedef enum logic [1:0] {
    MODE_CHASE  = 2'b00,
    MODE_BOUNCE = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_FILL   = 2'b11
  } mode_e;

  mode_e             r_mode_q;
  logic [DIV_W-1:0]  r_cnt;
  logic [N_LEDS-1:0] r_led;
  logic              r_step;
  logic [PW-1:0]     r_pos;
  logic              r_dir;
  logic [PW-1:0]     r_k;
  logic              r_started;

  mode_e             w_mode;
  logic              w_mode_chg;
  logic              w_tick;
  logic [N_LEDS-1:0] w_start_led;
  logic [N_LEDS-1:0] w_adv_led;
  logic [PW-1:0]     w_adv_pos;
  logic              w_adv_dir;
  logic [PW-1:0]     w_adv_k;

  mode_e             w_mode_nxt;
  logic [DIV_W-1:0]  w_cnt_nxt;
  logic [N_LEDS-1:0] w_led_nxt;
  logic              w_step_nxt;
  logic [PW-1:0]     w_pos_nxt;
  logic              w_dir_nxt;
  logic [PW-1:0]     w_k_nxt;
  logic              w_started_nxt;

  assign w_mode     = mode_e'(mode);
  assign w_mode_chg = (w_mode != r_mode_q);
  assign w_tick     = en && (r_cnt >= period);

  always_comb begin : start_pattern
    w_start_led = '0;
    case (w_mode)
      MODE_CHASE, MODE_BOUNCE: w_start_led[0] = 1'b1;
      MODE_BLINK:              w_start_led = '1;
      default:                 w_start_led = '0;
    endcase
  end

  always_comb begin : advance
    w_adv_led = r_led;
    w_adv_pos = r_pos;
    w_adv_dir = r_dir;
    w_adv_k   = r_k;
    case (r_mode_q)
      MODE_CHASE: begin
        for (int i = 0; i < N_LEDS; i++) begin
          w_adv_led[i] = r_led[(i + N_LEDS - 1) % N_LEDS];
        end
      end
      MODE_BOUNCE: begin
        // r_dir=1 walks toward the top LED; direction flips on arrival at an end
        if (N_LEDS > 1) begin
          if (r_dir) begin
            w_adv_pos = r_pos + PW'(1);
            if (w_adv_pos == PW'(N_LEDS - 1)) w_adv_dir = 1'b0;
          end else begin
            w_adv_pos = r_pos - PW'(1);
            if (w_adv_pos == '0) w_adv_dir = 1'b1;
          end
        end
        for (int i = 0; i < N_LEDS; i++) begin
          w_adv_led[i] = (w_adv_pos == PW'(i));
        end
      end
      MODE_BLINK: begin
        w_adv_led = ~r_led;
      end
      default: begin
        w_adv_k = (r_k == PW'(N_LEDS)) ? '0 : r_k + PW'(1);
        for (int i = 0; i < N_LEDS; i++) begin
          w_adv_led[i] = (PW'(i) < w_adv_k);
        end
      end
    endcase
  end

  always_comb begin : next_state
    w_mode_nxt    = r_mode_q;
    w_cnt_nxt     = r_cnt;
    w_led_nxt     = r_led;
    w_step_nxt    = 1'b0;
    w_pos_nxt     = r_pos;
    w_dir_nxt     = r_dir;
    w_k_nxt       = r_k;
    w_started_nxt = r_started;
    // The post-reset load and a mode change both restart the pattern; any tick is dropped
    if (!r_started || w_mode_chg) begin
      w_started_nxt = 1'b1;
      w_mode_nxt    = w_mode;
      w_cnt_nxt     = '0;
      w_led_nxt     = w_start_led;
      w_pos_nxt     = '0;
      w_dir_nxt     = 1'b1;
      w_k_nxt       = '0;
    end else if (w_tick) begin
      w_cnt_nxt  = '0;
      w_led_nxt  = w_adv_led;
      w_pos_nxt  = w_adv_pos;
      w_dir_nxt  = w_adv_dir;
      w_k_nxt    = w_adv_k;
      w_step_nxt = 1'b1;
    end else if (en) begin
      w_cnt_nxt = r_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode_q  <= w_mode;
      r_cnt     <= '0;
      r_led     <= '0;
      r_step    <= 1'b0;
      r_pos     <= '0;
      r_dir     <= 1'b1;
      r_k       <= '0;
      r_started <= 1'b0;
    end else begin
      r_mode_q  <= w_mode_nxt;
      r_cnt     <= w_cnt_nxt;
      r_led     <= w_led_nxt;
      r_step    <= w_step_nxt;
      r_pos     <= w_pos_nxt;
      r_dir     <= w_dir_nxt;
      r_k       <= w_k_nxt;
      r_started <= w_started_nxt;
    end
  end

  assign led  = r_led;
  assign step = r_step;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - Scoreboard bench for led_sequencer with N_LEDS=4
// Stimulus queues expected led/step per edge; a negedge monitor pops and compares.
module tb_led_sequencer;

  logic       clk;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [7:0] period;
  logic [3:0] led;
  logic       step;

  int total = 0;
  int bad   = 0;

  logic [3:0] q_led[$];
  logic       q_step[$];
  string      q_name[$];

  led_sequencer #(.N_LEDS(4), .DIV_W(8)) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .mode   (mode),
    .period (period),
    .led    (led),
    .step   (step)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (q_led.size() > 0) begin
      logic [3:0] e_led;
      logic       e_step;
      string      nm;
      e_led  = q_led.pop_front();
      e_step = q_step.pop_front();
      nm     = q_name.pop_front();
      total++;
      if (led !== e_led) begin
        bad++;
        $display("FAIL %s led got=%b want=%b", nm, led, e_led);
      end
      total++;
      if (step !== e_step) begin
        bad++;
        $display("FAIL %s step got=%b want=%b", nm, step, e_step);
      end
    end
  end

  task automatic cy(input logic [3:0] el, input logic es, input string nm);
    @(posedge clk);
    #1;
    q_led.push_back(el);
    q_step.push_back(es);
    q_name.push_back(nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; period = 8'd0;
    cy(4'b0000, 1'b0, "reset0");
    cy(4'b0000, 1'b0, "reset1");

    rst = 1'b0;
    cy(4'b0001, 1'b0, "chase_start");
    cy(4'b0010, 1'b1, "chase1");
    cy(4'b0100, 1'b1, "chase2");
    cy(4'b1000, 1'b1, "chase3");
    cy(4'b0001, 1'b1, "chase_wrap");
    cy(4'b0010, 1'b1, "chase5");
    cy(4'b0100, 1'b1, "chase6");

    mode = 2'b01;
    cy(4'b0001, 1'b0, "mode_over_tick");
    cy(4'b0010, 1'b1, "bounce1");
    cy(4'b0100, 1'b1, "bounce2");
    cy(4'b1000, 1'b1, "bounce_top");
    cy(4'b0100, 1'b1, "bounce_down1");
    cy(4'b0010, 1'b1, "bounce_down2");
    cy(4'b0001, 1'b1, "bounce_bottom");
    cy(4'b0010, 1'b1, "bounce_up1");
    cy(4'b0100, 1'b1, "bounce_up2");
    cy(4'b1000, 1'b1, "bounce_top2");

    rst = 1'b1;
    cy(4'b0000, 1'b0, "rst_mid");
    rst = 1'b0;
    cy(4'b0001, 1'b0, "restart_load");
    cy(4'b0010, 1'b1, "restart_up");
    cy(4'b0100, 1'b1, "restart_up2");

    mode = 2'b10;
    cy(4'b1111, 1'b0, "blink_load");
    cy(4'b0000, 1'b1, "blink1");
    cy(4'b1111, 1'b1, "blink2");

    mode = 2'b11;
    cy(4'b0000, 1'b0, "fill_load");
    cy(4'b0001, 1'b1, "fill1");
    cy(4'b0011, 1'b1, "fill2");
    cy(4'b0111, 1'b1, "fill3");
    cy(4'b1111, 1'b1, "fill_full");
    cy(4'b0000, 1'b1, "fill_wrap");
    cy(4'b0001, 1'b1, "fill_again");

    mode = 2'b00; period = 8'd3;
    cy(4'b0001, 1'b0, "pre_load");
    cy(4'b0001, 1'b0, "pre_cnt1");
    cy(4'b0001, 1'b0, "pre_cnt2");
    cy(4'b0001, 1'b0, "pre_cnt3");
    cy(4'b0010, 1'b1, "pre_tick");
    cy(4'b0010, 1'b0, "pre_cnt1b");
    cy(4'b0010, 1'b0, "pre_cnt2b");

    en = 1'b0;
    for (int i = 0; i < 5; i++) cy(4'b0010, 1'b0, "freeze");
    en = 1'b1;
    cy(4'b0010, 1'b0, "resume_cnt3");
    cy(4'b0100, 1'b1, "resume_tick");

    cy(4'b0100, 1'b0, "drop_cnt1");
    cy(4'b0100, 1'b0, "drop_cnt2");
    period = 8'd1;
    cy(4'b1000, 1'b1, "period_drop");

    en = 1'b0; mode = 2'b01;
    cy(4'b0001, 1'b0, "mode_while_off");
    cy(4'b0001, 1'b0, "hold_off");
    en = 1'b1; period = 8'd0;
    cy(4'b0010, 1'b1, "after_off");

    repeat (3) @(posedge clk);
    #1;
    total++;
    if (q_led.size() != 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", q_led.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_sequencer.md
LED_SEQUENCER -- requirements
Module: led_sequencer

Interface
REQ-001 The block SHALL have a parameter N_LEDS, default 4, giving the number of LED outputs (legal range 1..32).
REQ-002 The block SHALL have a parameter DIV_W, default 24, giving the prescaler width in bits.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port en, input, 1 bit: prescaler and pattern advance enable.
REQ-006 The block SHALL have port mode, input, 2 bits, with these encodings:
- 00 chase
- 01 bounce
- 10 blink
- 11 fill
REQ-007 The block SHALL have port period, input, DIV_W bits: step interval, equal to period+1 enabled clocks.
REQ-008 The block SHALL have port led, output, N_LEDS bits: the registered LED pattern.
REQ-009 The block SHALL have port step, output, 1 bit: a registered one-cycle pulse on each pattern advance.

Function
REQ-010 The prescaler counter cnt (DIV_W bits) SHALL behave as follows when en=1:
- If cnt >= period, it SHALL produce a tick and load cnt to 0.
- Otherwise it SHALL increment cnt.
REQ-011 period=0 SHALL give a tick on every enabled cycle.
REQ-012 Lowering period below the current cnt SHALL cause a tick on the next enabled cycle.
REQ-013 When en=0, cnt, led and the internal state SHALL hold, and step SHALL be 0.
REQ-014 On a tick, led SHALL update to the next pattern at the same clock edge that sets step=1; latency from the tick condition to the led change SHALL be 1 clock.
REQ-015 Chase SHALL start at led=1 (bit 0). Each tick SHALL rotate led left by one, with bit N_LEDS-1 wrapping to bit 0.
REQ-016 Bounce SHALL drive led as a one-hot encoding of position pos, using direction dir:
- Start: pos=0, dir=up.
- Each tick: pos moves by one in the direction of dir.
- On reaching pos=N_LEDS-1, dir SHALL become down.
- On reaching pos=0, dir SHALL become up.
- The end LEDs SHALL be lit for exactly one step per pass.
- With N_LEDS=1, led SHALL remain 1.
REQ-017 Blink SHALL start with led all ones and invert all bits on each tick.
REQ-018 Fill SHALL use a level counter k in the range 0..N_LEDS:
- Start: k=0.
- led[i] SHALL be 1 exactly when i < k.
- Each tick SHALL increment k, and k=N_LEDS SHALL wrap to 0.
- The fill cycle is therefore N_LEDS+1 steps long.
REQ-019 The block SHALL register the mode in effect as mode_q. When mode differs from mode_q, the next edge SHALL:
- load mode_q from mode;
- clear cnt to 0;
- load led with the start pattern of the new mode, with pos=0, dir=up and k=0;
- set step=0.
REQ-020 A mode change SHALL take priority over a coincident tick; the tick is discarded.
REQ-021 A mode change SHALL be applied even when en=0.
REQ-022 The block SHALL keep a started flag. On the first edge with rst=0 after reset, it SHALL load the start pattern of the current mode, set started=1 and set step=0. Neither en nor a tick is required for this load.
REQ-023 Priority SHALL be, highest first: rst, then the start load, then a mode change, then a tick, then hold.
REQ-024 All arithmetic SHALL be unsigned and wrap-free within the declared widths. pos and k SHALL be sized to hold N_LEDS.

Reset
REQ-025 While rst=1 at a clock edge, the block SHALL force all of the following, regardless of en, mode and period:
- led=0, step=0, cnt=0
- pos=0, dir=up, k=0
- started=0
- mode_q=mode
REQ-026 Assertion of rst mid-sequence or mid-count SHALL take effect at the next edge, with no partial step.

Verification (N_LEDS=4, period=0, en=1 unless stated)
REQ-027 Chase: release rst with mode=00; led SHALL be 0001 at the first edge, then 0010, 0100, 1000, 0001, with step=1 on each of the four advances.
REQ-028 Bounce: with mode=01, led SHALL follow 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
REQ-029 Blink then fill: mode=10 SHALL give 1111, 0000, 1111; switching to mode=11 SHALL give 0000 (reload, step=0), then 0001, 0011, 0111, 1111, 0000.
REQ-030 Prescaler: with period=3, led SHALL advance every 4 cycles. Holding en=0 for 5 cycles at cnt=2 SHALL freeze led and cnt, and the advance SHALL occur 1 enabled cycle after en returns to 1.
REQ-031 Mode change coincident with a tick: with chase at 0100 and mode set to 01 on the tick cycle, the next led SHALL be 0001, with step=0 and cnt=0.
REQ-032 Reset mid-run: assert rst for 1 cycle with bounce at 1000 (dir=down); led SHALL be 0000 at that edge. The next edge SHALL reload 0001 with dir=up, so the following tick gives 0010.
